// File: rtl/vpi_pub_access_sched_if.sv
// Request/response bus between the requester agents and the public-bank scheduler.
// Requesters drive the packed per-requester slices; the scheduler grants and answers.
interface vpi_pub_access_sched_if #(
    parameter int NREQ = 2,
    parameter int DW   = 24,
    parameter int IDW  = 3
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*3-1:0]  req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_gnt;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_gnt, rsp_valid, rsp_id, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/vpi_pub_access_sched.sv
// Round-robin scheduler serialising NREQ requesters onto the small public register
// bank; one access per grant, one response per access (IDLE -> XFER -> RESP).
module vpi_pub_access_sched #(
    parameter int NREQ = 2,
    parameter int DW   = 24,
    parameter int IDW  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    vpi_pub_access_sched_if.slave bus,
    input  logic [15:0]           testin,
    output logic                  onebit,
    output logic [1:0]            twoone,
    output logic                  onetwo_1,
    output logic                  onetwo_2,
    output logic [1:0]            ftto_3,
    output logic [1:0]            ftto_4,
    output logic [23:0]           testout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [IDW-1:0] ptr_reg, ptr_next;
    logic [IDW-1:0] id_reg, id_next;
    logic           write_reg, write_next;
    logic [2:0]     addr_reg, addr_next;
    logic [DW-1:0]  wdata_reg, wdata_next;

    logic [IDW-1:0] rsp_id_reg, rsp_id_next;
    logic [DW-1:0]  rsp_rdata_reg, rsp_rdata_next;
    logic           rsp_err_reg, rsp_err_next;

    logic           onebit_reg, onebit_next;
    logic [1:0]     twoone_reg, twoone_next;
    logic           onetwo_1_reg, onetwo_1_next;
    logic           onetwo_2_reg, onetwo_2_next;
    logic [1:0]     ftto_3_reg, ftto_3_next;
    logic [1:0]     ftto_4_reg, ftto_4_next;
    logic [23:0]    testout_reg, testout_next;

    // Per-requester views of the packed request buses
    logic [2:0]     addr_arr  [NREQ];
    logic [DW-1:0]  wdata_arr [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign addr_arr[gi]    = bus.req_addr[gi*3 +: 3];
            assign wdata_arr[gi]   = bus.req_wdata[gi*DW +: DW];
            assign bus.req_gnt[gi] = (state_reg == XFER) && (id_reg == IDW'(gi));
        end
    endgenerate

    // Arbiter: first valid at or after the pointer, then wrap to the low indices
    logic           found;
    logic [IDW-1:0] pick;
    logic           sel_write;
    logic [2:0]     sel_addr;
    logic [DW-1:0]  sel_wdata;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j] && (IDW'(j) >= ptr_reg)) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && bus.req_valid[j]) begin
                found = 1'b1;
                pick  = IDW'(j);
            end
        end
    end

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (pick == IDW'(j)) begin
                sel_write = bus.req_write[j];
                sel_addr  = addr_arr[j];
                sel_wdata = wdata_arr[j];
            end
        end
    end

    // Zero-extended read view of the latched address
    logic [DW-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (addr_reg)
            3'd0: rd_mux[0]     = onebit_reg;
            3'd1: rd_mux[1:0]   = twoone_reg;
            3'd2: rd_mux[0]     = onetwo_1_reg;
            3'd3: rd_mux[0]     = onetwo_2_reg;
            3'd4: rd_mux[1:0]   = ftto_3_reg;
            3'd5: rd_mux[1:0]   = ftto_4_reg;
            3'd6: rd_mux[23:0]  = testout_reg;
            default: rd_mux[15:0] = testin;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        id_next        = id_reg;
        write_next     = write_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        rsp_id_next    = rsp_id_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        onebit_next    = onebit_reg;
        twoone_next    = twoone_reg;
        onetwo_1_next  = onetwo_1_reg;
        onetwo_2_next  = onetwo_2_reg;
        ftto_3_next    = ftto_3_reg;
        ftto_4_next    = ftto_4_reg;
        testout_next   = testout_reg;

        case (state_reg)
            IDLE: begin
                if (found) begin
                    id_next    = pick;
                    write_next = sel_write;
                    addr_next  = sel_addr;
                    wdata_next = sel_wdata;
                    state_next = XFER;
                end
            end
            XFER: begin
                ptr_next       = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + IDW'(1);
                rsp_id_next    = id_reg;
                rsp_err_next   = write_reg && (addr_reg == 3'd7);
                rsp_rdata_next = write_reg ? '0 : rd_mux;
                if (write_reg) begin
                    case (addr_reg)
                        3'd0: onebit_next   = wdata_reg[0];
                        3'd1: twoone_next   = wdata_reg[1:0];
                        3'd2: onetwo_1_next = wdata_reg[0];
                        3'd3: onetwo_2_next = wdata_reg[0];
                        3'd4: ftto_3_next   = wdata_reg[1:0];
                        3'd5: ftto_4_next   = wdata_reg[1:0];
                        3'd6: testout_next  = wdata_reg[23:0];
                        default: ;  // testin is read-only; flagged via rsp_err
                    endcase
                end
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            id_reg        <= '0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            rsp_id_reg    <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
            onebit_reg    <= 1'b0;
            twoone_reg    <= '0;
            onetwo_1_reg  <= 1'b0;
            onetwo_2_reg  <= 1'b0;
            ftto_3_reg    <= '0;
            ftto_4_reg    <= '0;
            testout_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            id_reg        <= id_next;
            write_reg     <= write_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            rsp_id_reg    <= rsp_id_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            onebit_reg    <= onebit_next;
            twoone_reg    <= twoone_next;
            onetwo_1_reg  <= onetwo_1_next;
            onetwo_2_reg  <= onetwo_2_next;
            ftto_3_reg    <= ftto_3_next;
            ftto_4_reg    <= ftto_4_next;
            testout_reg   <= testout_next;
        end
    end

    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

    assign onebit   = onebit_reg;
    assign twoone   = twoone_reg;
    assign onetwo_1 = onetwo_1_reg;
    assign onetwo_2 = onetwo_2_reg;
    assign ftto_3   = ftto_3_reg;
    assign ftto_4   = ftto_4_reg;
    assign testout  = testout_reg;

endmodule
